// File: rtl/vote_session_ctrl.sv
// ---------------------------------------------------------------------------
// vote_session_ctrl
//
// Runs one four-voter ballot session for the majority-vote datapath.
// A session opens on `start` in IDLE. Ballots are then collected through a
// per-voter strobe/ack handshake. When all four voters have voted, the
// recorded tally is turned into a one-hot verdict that is published with a
// `done` window of HOLD_CYC cycles.
//
// Optional feature (macro VOTE_TIMEOUT_EN):
//   When the macro is defined, COLLECT is forced closed after TIMEOUT_CYC
//   cycles. Voters that have not voted count as "no".
//   When the macro is undefined, COLLECT waits for all four voters.
//
// Parameters:
//   TIMEOUT_CYC  maximum COLLECT cycles before forced close (2..255)
//   HOLD_CYC     cycles `done` stays high after a verdict (1..255)
//
// Ports:
//   clk      in   1  clock, rising edge
//   rst      in   1  asynchronous, active-high reset
//   start    in   1  session open request, sampled only in IDLE
//   cast     in   4  per-voter ballot strobe, bit i = voter i
//   ballot   in   4  per-voter value (1 = yes), qualified by cast[i]
//   ack      out  4  registered one-cycle acceptance per voter
//   voted    out  4  voters whose ballot is recorded this session
//   busy     out  1  high in COLLECT and DECIDE
//   done     out  1  high during the HOLD_CYC-cycle HOLD window
//   result   out  3  one-hot verdict {pass, tie, fail}; 000 = none
//   yes_cnt  out  3  number of yes ballots, 0..4
// ---------------------------------------------------------------------------
module vote_session_ctrl #(
    parameter int TIMEOUT_CYC = 16,
    parameter int HOLD_CYC    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] cast,
    input  logic [3:0] ballot,
    output logic [3:0] ack,
    output logic [3:0] voted,
    output logic       busy,
    output logic       done,
    output logic [2:0] result,
    output logic [2:0] yes_cnt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_DECIDE,
        S_HOLD
    } state_t;

    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);
    localparam logic [7:0] HOLD_LAST    = 8'(HOLD_CYC - 1);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] accept;      // casts taken this cycle (new voters only)
    logic [2:0] add_cnt;     // yes ballots among the accepted casts
    logic [7:0] hold_cnt;
    logic       hold_last;
    logic       timeout_hit;

    assign hold_last = (hold_cnt == HOLD_LAST);

`ifdef VOTE_TIMEOUT_EN
    logic [7:0] to_cnt;

    // The counter reads 0 in the first COLLECT cycle. A match therefore
    // marks the TIMEOUT_CYC-th COLLECT cycle. Casts in that cycle still
    // count, because `accept` is evaluated regardless of the timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            to_cnt <= '0;
        end else if (state == S_IDLE && start) begin
            to_cnt <= '0;
        end else if (state == S_COLLECT) begin
            to_cnt <= to_cnt + 8'd1;
        end
    end

    assign timeout_hit = (to_cnt == TIMEOUT_LAST);
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT_LAST;
    assign timeout_hit    = 1'b0;
`endif

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and output decode
    always_comb begin
        // NOTE: every signal written here gets a default first, so that no
        // path through the case statement can leave a latch behind.
        state_nxt = state;
        accept    = 4'b0000;
        busy      = 1'b0;
        done      = 1'b0;
        add_cnt   = 3'd0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    state_nxt = S_COLLECT;
                end
            end
            S_COLLECT: begin
                busy    = 1'b1;
                accept  = cast & ~voted;
                add_cnt = {2'b00, accept[0] & ballot[0]}
                        + {2'b00, accept[1] & ballot[1]}
                        + {2'b00, accept[2] & ballot[2]}
                        + {2'b00, accept[3] & ballot[3]};
                if ((voted | accept) == 4'b1111 || timeout_hit) begin
                    state_nxt = S_DECIDE;
                end
            end
            S_DECIDE: begin
                busy      = 1'b1;
                state_nxt = S_HOLD;
            end
            S_HOLD: begin
                done = 1'b1;
                if (hold_last) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Session datapath. Results stay visible after HOLD until the next
    // accepted start clears them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack      <= 4'b0000;
            voted    <= 4'b0000;
            yes_cnt  <= 3'd0;
            result   <= 3'b000;
            hold_cnt <= 8'd0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments, so every
            // register samples the pre-edge value of the others.
            ack <= accept;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        voted   <= 4'b0000;
                        yes_cnt <= 3'd0;
                        result  <= 3'b000;
                    end
                end
                S_COLLECT: begin
                    voted <= voted | accept;
                    // Only new voters are accepted, so the sum is capped at 4.
                    yes_cnt <= yes_cnt + add_cnt;
                end
                S_DECIDE: begin
                    hold_cnt <= 8'd0;
                    if (yes_cnt >= 3'd3) begin
                        result <= 3'b100;
                    end else if (yes_cnt == 3'd2) begin
                        result <= 3'b010;
                    end else begin
                        result <= 3'b001;
                    end
                end
                S_HOLD: begin
                    hold_cnt <= hold_cnt + 8'd1;
                end
                default: ;
            endcase
        end
    end

endmodule
